// File: rtl/fifo_sync.sv
// fifo_sync: single-clock synchronous FIFO placed behind the write-side
// controller. The controller watches `words` to decide when to switch
// between writing and reading; a downstream consumer drains the FIFO through
// rd_en / rd_data / rd_valid.
//
// Ports
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush, wins over wr_en / rd_en in the same cycle
//   wr_en         write request
//   wr_data       write data, captured when the write is accepted
//   rd_en         read request
//   rd_data       registered read data, holds its value between reads
//   rd_valid      one-cycle pulse marking a freshly popped rd_data
//   words         occupancy, 0..DEPTH
//   full, empty   words == DEPTH / words == 0
//   almost_full   words >= AF_LEVEL
//   almost_empty  words <= AE_LEVEL
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module fifo_sync #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    words,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Status flags decode straight off the registered count, so they carry
    // no extra latency relative to words.
    assign full         = (words == DEPTH_C);
    assign empty        = (words == '0);
    assign almost_full  = (words >= AF_C);
    assign almost_empty = (words <= AE_C);

    // A read frees a slot in the same edge, so a write at full is still
    // accepted when paired with a read. At empty the read is refused even if
    // a write arrives: there is no fall-through path.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            words     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            // rd_data is intentionally kept so the consumer still sees the
            // last popped word after a flush.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            words     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;

            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end

            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end

            // Count only moves when exactly one side is accepted; the accept
            // terms keep it inside 0..DEPTH without any saturation logic.
            case ({wr_acc, rd_acc})
                2'b10:   words <= words + 1'b1;
                2'b01:   words <= words - 1'b1;
                default: words <= words;
            endcase

            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] words;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int fails  = 0;

    // Reference model: a queue holding the FIFO contents plus the expected
    // registered outputs.
    logic [7:0] q[$];
    logic [7:0] m_rd_data;
    bit         m_rd_valid;
    bit         m_ovf;
    bit         m_udf;

    fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .words        (words),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy must never leave 0..DEPTH.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!(words <= 4'(DEPTH))) begin
                fails++;
                $display("FAIL words_range got=%0d max=%0d", words, DEPTH);
            end
        end
    end

    task automatic model_reset();
        q.delete();
        m_rd_data  = 8'h00;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    // Drive one clock of stimulus, update the model at the edge, then return
    // 1 time unit after the edge with inputs idle.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit can_rd;
        bit can_wr;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_udf      = 1'b0;
        end else begin
            can_rd = r && (q.size() > 0);
            can_wr = w && ((q.size() < DEPTH) || can_rd);
            if (can_rd) m_rd_data = q.pop_front();
            m_rd_valid = can_rd;
            if (can_wr) q.push_back(d);
            if (w && !can_wr) m_ovf = 1'b1;
            if (r && !can_rd) m_udf = 1'b1;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        if (words !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
            almost_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_status words=%0d empty=%b full=%b ae=%b af=%b exp 0 1 0 1 0",
                     words, empty, full, almost_empty, almost_full);
        end
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs rd_data=%h rd_valid=%b ovf=%b udf=%b exp 00 0 0 0",
                     rd_data, rd_valid, overflow, underflow);
        end
        checks++;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Build up words=3 with rd_valid high, then reset mid-cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        if (words !== 4'd3 || rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_setup words=%0d rd_valid=%b exp 3 1", words, rd_valid);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (words !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_async words=%0d empty=%b rd_valid=%b exp 0 1 0",
                     words, empty, rd_valid);
        end
        checks++;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (words !== 4'((i > 8) ? 8 : i) || full !== (i >= 8) ||
                almost_full !== (i >= 6) || overflow !== (i >= 9)) begin
                fails++;
                $display("FAIL fill_%0d words=%0d full=%b af=%b ovf=%b exp %0d %b %b %b", i,
                         words, full, almost_full, overflow, (i > 8) ? 8 : i, i >= 8, i >= 6,
                         i >= 9);
            end
            checks++;
        end
    endtask

    // Continues from the full state left by test_fill_overflow.
    task automatic test_drain_underflow();
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (k <= 8) begin
                if (rd_valid !== 1'b1 || rd_data !== 8'(k) || words !== 4'(8 - k) ||
                    underflow !== 1'b0) begin
                    fails++;
                    $display("FAIL drain_%0d rd_valid=%b rd_data=%h words=%0d udf=%b exp 1 %h %0d 0",
                             k, rd_valid, rd_data, words, underflow, 8'(k), 8 - k);
                end
            end else begin
                if (rd_valid !== 1'b0 || rd_data !== 8'h08 || empty !== 1'b1 ||
                    underflow !== 1'b1) begin
                    fails++;
                    $display("FAIL drain_extra rd_valid=%b rd_data=%h empty=%b udf=%b exp 0 08 1 1",
                             rd_valid, rd_data, empty, underflow);
                end
            end
            checks++;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] oldest;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        oldest = q[0];
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        if (rd_valid !== 1'b1 || rd_data !== oldest || words !== 4'd8 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL simul_full rd_valid=%b rd_data=%h words=%0d ovf=%b exp 1 %h 8 0",
                     rd_valid, rd_data, words, overflow, oldest);
        end
        checks++;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                fails++;
                $display("FAIL simul_drain_%0d rd_valid=%b rd_data=%h exp 1 %h",
                         i, rd_valid, rd_data, m_rd_data);
            end
            checks++;
        end
        if (rd_data !== 8'hAA || underflow !== 1'b0) begin
            fails++;
            $display("FAIL simul_last rd_data=%h udf=%b exp aa 0", rd_data, underflow);
        end
        checks++;
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        if (words !== 4'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL simul_empty words=%0d udf=%b rd_valid=%b exp 1 1 0",
                     words, underflow, rd_valid);
        end
        checks++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        if (rd_valid !== 1'b1 || rd_data !== 8'h55 || words !== 4'd0) begin
            fails++;
            $display("FAIL simul_empty_read rd_valid=%b rd_data=%h words=%0d exp 1 55 0",
                     rd_valid, rd_data, words);
        end
        checks++;
    endtask

    // Controller-style hysteresis: fill to 5, drain to 2, ten rounds.
    task automatic test_wraparound();
        logic [7:0] next_val;
        int max_words;
        next_val  = 8'h00;
        max_words = 0;
        apply_reset();
        for (int round = 0; round < 10; round++) begin
            for (int n = 0; n < 16 && q.size() < 5; n++) begin
                cycle(1'b1, next_val, 1'b0, 1'b0);
                next_val = next_val + 8'h01;
                if (int'(words) > max_words) max_words = int'(words);
            end
            for (int n = 0; n < 16 && q.size() > 2; n++) begin
                cycle(1'b0, 8'h00, 1'b1, 1'b0);
                if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                    fails++;
                    $display("FAIL wrap_r%0d_order rd_valid=%b rd_data=%h exp 1 %h",
                             round, rd_valid, rd_data, m_rd_data);
                end
                checks++;
            end
        end
        if (max_words > 5 || overflow !== 1'b0 || underflow !== 1'b0 || words !== 4'd2) begin
            fails++;
            $display("FAIL wrap_end max_words=%0d ovf=%b udf=%b words=%0d exp <=5 0 0 2",
                     max_words, overflow, underflow, words);
        end
        checks++;
    endtask

    task automatic test_clr();
        logic [7:0] held;
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        if (words !== 4'd4 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL clr_setup words=%0d ovf=%b exp 4 1", words, overflow);
        end
        checks++;
        held = m_rd_data;
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        if (words !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== held) begin
            fails++;
            $display("FAIL clr_prio words=%0d empty=%b ovf=%b rd_valid=%b rd_data=%h exp 0 1 0 0 %h",
                     words, empty, overflow, rd_valid, rd_data, held);
        end
        checks++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || words !== 4'd0) begin
            fails++;
            $display("FAIL clr_nothing_stored rd_valid=%b udf=%b words=%0d exp 0 1 0",
                     rd_valid, underflow, words);
        end
        checks++;
    endtask

    task automatic test_random();
        bit w, r, c;
        logic [7:0] d;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            d = 8'($urandom);
            cycle(w, d, r, c);
            if (words !== 4'(q.size()) || full !== (q.size() == DEPTH) ||
                empty !== (q.size() == 0) || almost_full !== (q.size() >= DEPTH - 2) ||
                almost_empty !== (q.size() <= 2)) begin
                fails++;
                $display("FAIL rand_status cyc=%0d words=%0d f=%b e=%b af=%b ae=%b exp words=%0d",
                         cyc, words, full, empty, almost_full, almost_empty, q.size());
            end
            checks++;
            if (rd_valid !== m_rd_valid || rd_data !== m_rd_data || overflow !== m_ovf ||
                underflow !== m_udf) begin
                fails++;
                $display("FAIL rand_regs cyc=%0d rv=%b rd=%h ovf=%b udf=%b exp %b %h %b %b",
                         cyc, rd_valid, rd_data, overflow, underflow, m_rd_valid, m_rd_data,
                         m_ovf, m_udf);
            end
            checks++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wraparound();
        test_clr();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
